// File: rtl/execution_stage_mdu_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide unit.
package execution_stage_mdu_pkg;

  // Widest operand mdu_abs can handle; XLEN must not exceed this.
  localparam int unsigned MDU_ABS_W = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_e;

  // Magnitude of a two's complement value when neg is set; callers zero-extend and truncate.
  function automatic logic [MDU_ABS_W-1:0] mdu_abs(input logic [MDU_ABS_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/execution_stage_mdu_if.sv
// Request/response bus between the execute stage and the multiply/divide unit.
interface execution_stage_mdu_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             zero_flag;
  logic             overflow_flag;
  logic             div_zero_flag;
  logic             busy;

  modport master (
    output flush, in_valid, op, operand_a, operand_b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, zero_flag, overflow_flag, div_zero_flag, busy
  );

  modport slave (
    input  flush, in_valid, op, operand_a, operand_b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, zero_flag, overflow_flag, div_zero_flag, busy
  );
endinterface

// File: rtl/execution_stage_mdu_divider_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle for XLEN cycles.
// done_o is high during the final iteration cycle; results are valid from the next cycle.
module mdu_divider_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int unsigned      CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic [XLEN:0]    trial;

  // Shifted partial remainder minus divisor; MSB set means the subtraction is rejected.
  assign trial       = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign done_o      = run_q && (cnt_q == CNT_LAST);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Load on start, then shift in one quotient bit per cycle until the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (kill_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (run_q) begin
      if (!trial[XLEN]) begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q == CNT_LAST) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/execution_stage_mdu.sv
// Multi-cycle RV32M-style multiply/divide unit for the execute stage.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply (IDLE->FIX->DONE).
module execution_stage_mdu
  import execution_stage_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic                clk,
  input logic                rst,
  execution_stage_mdu_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*XLEN-1:0]  acc_q;
  logic               qneg_q, rneg_q;
  logic               in_ready_q, busy_q, out_valid_q;
  logic               zero_q, ovf_q, dz_q;
  logic [XLEN-1:0]    result_q;

  mdu_op_e            op_in;
  logic               sa_in, sb_in, dz_in, ov_in, accept;
  logic [XLEN-1:0]    abs_a, abs_b, spec_res, fix_res, quo_fix, rem_fix;
  logic [2*XLEN-1:0]  prod;
  logic               div_done;
  logic [XLEN-1:0]    div_quo, div_rem;

  assign op_in  = mdu_op_e'(bus.op);
  assign sa_in  = op_a_signed(op_in) && bus.operand_a[XLEN-1];
  assign sb_in  = op_b_signed(op_in) && bus.operand_b[XLEN-1];
  assign abs_a  = XLEN'(mdu_abs(MDU_ABS_W'(bus.operand_a), sa_in));
  assign abs_b  = XLEN'(mdu_abs(MDU_ABS_W'(bus.operand_b), sb_in));
  assign dz_in  = op_is_div(op_in) && (bus.operand_b == '0);
  assign ov_in  = (op_in == OP_DIV || op_in == OP_REM) &&
                  (bus.operand_a == MIN_VAL) && (bus.operand_b == '1);
  assign accept = bus.in_valid && in_ready_q && !bus.flush;

  mdu_divider_core #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept && op_is_div(op_in) && !dz_in && !ov_in),
    .kill_i      (bus.flush),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

`ifndef MDU_FAST_MUL_EN
  localparam int unsigned      CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mcand_q;
  logic [XLEN:0]    mul_sum;
  // acc_q holds {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif

  assign prod    = qneg_q ? -acc_q : acc_q;
  assign quo_fix = qneg_q ? -div_quo : div_quo;
  assign rem_fix = rneg_q ? -div_rem : div_rem;

  // Result for divide-by-zero and signed overflow, known at accept time.
  always_comb begin
    spec_res = '0;
    if (dz_in)      spec_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : bus.operand_a;
    else if (ov_in) spec_res = (op_in == OP_DIV) ? MIN_VAL : '0;
  end

  // Sign-corrected half/quotient/remainder selection used in FIX.
  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // Control FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      tag_q       <= '0;
      acc_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
`ifndef MDU_FAST_MUL_EN
      cnt_q       <= '0;
      mcand_q     <= '0;
`endif
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
`ifndef MDU_FAST_MUL_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            tag_q      <= bus.tag_in;
            qneg_q     <= sa_in ^ sb_in;
            rneg_q     <= sa_in;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (dz_in || ov_in) begin
              result_q    <= spec_res;
              zero_q      <= (spec_res == '0);
              dz_q        <= dz_in;
              ovf_q       <= ov_in;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (!op_is_div(op_in)) begin
`ifdef MDU_FAST_MUL_EN
              acc_q   <= (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
              state_q <= S_FIX;
`else
              acc_q   <= {{XLEN{1'b0}}, abs_b};
              mcand_q <= abs_a;
              cnt_q   <= '0;
              state_q <= S_MUL;
`endif
            end else begin
              state_q <= S_DIV;
            end
          end
        end
`ifndef MDU_FAST_MUL_EN
        S_MUL: begin
          acc_q <= {mul_sum, acc_q[XLEN-1:1]};
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_DIV: if (div_done) state_q <= S_FIX;
        S_FIX: begin
          result_q    <= fix_res;
          zero_q      <= (fix_res == '0);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.busy          = busy_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.result        = result_q;
  assign bus.tag_out       = tag_q;
  assign bus.zero_flag     = zero_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.div_zero_flag = dz_q;
endmodule

// File: tb/tb_execution_stage_mdu.sv
// Self-checking bench for execution_stage_mdu against an arithmetic reference model.
module tb_execution_stage_mdu;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  execution_stage_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  execution_stage_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic [2:0]  flg;   // {zero, overflow, div_zero}
    int          lat;
  } vec_t;

  // Reference: plain integer arithmetic following the RV32M rules.
  function automatic void ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic dz);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    ov = 1'b0; dz = 1'b0; r = '0;
    case (op)
      MUL:    begin p = ua * ub; r = p[31:0];  end
      MULH:   begin p = sa * sb; r = p[63:32]; end
      MULHSU: begin p = sa * ub; r = p[63:32]; end
      MULHU:  begin p = ua * ub; r = p[63:32]; end
      DIV: if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end
           else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; ov = 1'b1; end
           else r = $signed(a) / $signed(b);
      DIVU: if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end else r = a / b;
      REM: if (b == 0) begin r = a; dz = 1'b1; end
           else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; ov = 1'b1; end
           else r = $signed(a) % $signed(b);
      default: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op when the unit is ready; lat counts edges from the accept edge to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                        output logic [2:0] flg, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.tag_in = tag;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = bus.result; tg = bus.tag_out;
    flg = {bus.zero_flag, bus.overflow_flag, bus.div_zero_flag};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
    checks++; if (bus.tag_out !== 5'h0) begin errors++; $display("FAIL reset_tag got %h exp 0", bus.tag_out); end
    checks++; if ({bus.zero_flag, bus.overflow_flag, bus.div_zero_flag} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {bus.zero_flag, bus.overflow_flag, bus.div_zero_flag}); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t dv [12];
    logic [31:0] r; logic [4:0] t; logic [2:0] f; int l;
    dv[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3'b000, MUL_LAT};
    dv[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3'b000, MUL_LAT};
    dv[2]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b100, MUL_LAT};
    dv[3]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 3'b000, DIV_LAT};
    dv[4]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 3'b000, DIV_LAT};
    dv[5]  = '{DIVU,   32'd100,      32'd7,        32'd14,       3'b000, DIV_LAT};
    dv[6]  = '{REMU,   32'd100,      32'd7,        32'd2,        3'b000, DIV_LAT};
    dv[7]  = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 3'b001, 1};
    dv[8]  = '{REM,    32'd5,        32'd0,        32'd5,        3'b001, 1};
    dv[9]  = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b010, 1};
    dv[10] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3'b110, 1};
    dv[11] = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, MUL_LAT};
    for (int i = 0; i < 12; i++) begin
      run_op(dv[i].op, dv[i].a, dv[i].b, 5'(i + 1), r, t, f, l);
      checks++; if (r !== dv[i].exp) begin errors++; $display("FAIL dir%0d_result got %h exp %h", i, r, dv[i].exp); end
      checks++; if (f !== dv[i].flg) begin errors++; $display("FAIL dir%0d_flags got %b exp %b", i, f, dv[i].flg); end
      checks++; if (t !== 5'(i + 1)) begin errors++; $display("FAIL dir%0d_tag got %h exp %h", i, t, 5'(i + 1)); end
      checks++; if (l != dv[i].lat) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, l, dv[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, er, r; logic [4:0] tag, t; logic [2:0] f; logic eov, edz;
    int l, el;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); a = pick(); b = pick(); tag = 5'($urandom);
      ref_mdu(op, a, b, er, eov, edz);
      el = (eov || edz) ? 1 : (op >= DIV ? DIV_LAT : MUL_LAT);
      run_op(op, a, b, tag, r, t, f, l);
      checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h exp %h", i, op, a, b, r, er); end
      checks++; if (f !== {er == 0, eov, edz}) begin errors++; $display("FAIL rnd%0d_flags got %b exp %b", i, f, {er == 0, eov, edz}); end
      checks++; if (t !== tag) begin errors++; $display("FAIL rnd%0d_tag got %h exp %h", i, t, tag); end
      checks++; if (l != el) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, l, el); end
    end
  endtask

  task automatic test_flush();
    logic saw; logic [31:0] r; logic [4:0] t; logic [2:0] f; int l; int guard = 0;
    while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.op = DIV; bus.operand_a = 32'd1000; bus.operand_b = 32'd3; bus.tag_in = 5'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    saw = 1'b0;
    repeat (9) begin @(posedge clk); #1; saw |= bus.out_valid; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
    repeat (40) begin @(posedge clk); #1; saw |= bus.out_valid; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL flush_no_result got %b exp 0", saw); end
    run_op(MUL, 32'd2, 32'd3, 5'd9, r, t, f, l);
    checks++; if (r !== 32'd6) begin errors++; $display("FAIL flush_next_result got %h exp 6", r); end
    checks++; if (t !== 5'd9) begin errors++; $display("FAIL flush_next_tag got %h exp 9", t); end
    // flush together with a request in IDLE must not accept it
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = DIVU; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_idle_accept got busy/valid/ready %b exp 001", {bus.busy, bus.out_valid, bus.in_ready}); end
    // flush while holding a result in DONE
    bus.out_ready = 1'b0;
    run_op(DIVU, 32'd5, 32'd0, 5'd3, r, t, f, l);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if ({bus.out_valid, bus.div_zero_flag, bus.in_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_done got valid/dz/ready %b exp 001", {bus.out_valid, bus.div_zero_flag, bus.in_ready}); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_stall();
    logic [31:0] r; logic [4:0] t; logic [2:0] f; int l;
    bus.out_ready = 1'b0;
    run_op(DIVU, 32'd100, 32'd7, 5'd17, r, t, f, l);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.out_valid, bus.in_ready, bus.result, bus.tag_out} !== {1'b1, 1'b0, 32'd14, 5'd17}) begin
        errors++; $display("FAIL stall%0d got valid %b ready %b result %h tag %h exp 1 0 0000000e 11",
                           i, bus.out_valid, bus.in_ready, bus.result, bus.tag_out); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL stall_release got ready/valid/busy %b exp 100", {bus.in_ready, bus.out_valid, bus.busy}); end
  endtask

  task automatic test_back_to_back();
    logic rdy_seen = 1'b0; int n; int guard = 0;
    while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.op = DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.tag_in = 5'd1;
    @(posedge clk); #1;
    bus.op = MUL; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.tag_in = 5'd2;
    n = 1;
    while (!bus.out_valid && n < 200) begin rdy_seen |= bus.in_ready; @(posedge clk); #1; n++; end
    checks++; if ({bus.result, bus.tag_out} !== {32'd14, 5'd1}) begin
      errors++; $display("FAIL b2b_first got %h tag %h exp 0000000e tag 01", bus.result, bus.tag_out); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b exp 0", rdy_seen); end
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_gap got ready/valid %b exp 10", {bus.in_ready, bus.out_valid}); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if ({bus.result, bus.tag_out} !== {32'd81, 5'd2}) begin
      errors++; $display("FAIL b2b_second got %h tag %h exp 00000051 tag 02", bus.result, bus.tag_out); end
    checks++; if (n != MUL_LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", n, MUL_LAT); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] r; logic [4:0] t; logic [2:0] f; int l; int guard = 0;
    while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    bus.in_valid = 1'b1; bus.op = MUL; bus.operand_a = 32'd12; bus.operand_b = 32'd12; bus.tag_in = 5'd30;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.busy, bus.out_valid, bus.result, bus.tag_out} !== {3'b100, 32'd0, 5'd0}) begin
      errors++; $display("FAIL rst_mid got ready %b busy %b valid %b result %h tag %h exp 1 0 0 0 0",
                         bus.in_ready, bus.busy, bus.out_valid, bus.result, bus.tag_out); end
    rst = 1'b0;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 5'd4, r, t, f, l);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL rst_mid_next got %h exp fffffffd", r); end
    checks++; if (l != DIV_LAT) begin errors++; $display("FAIL rst_mid_latency got %0d exp %0d", l, DIV_LAT); end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.operand_a = '0;
    bus.operand_b = '0; bus.tag_in = '0; bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_stall();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
